// File: rtl/pc_gen_stage_pkg.sv
// pc_gen_pkg: shared types and constants for the PC generation stage.
package pc_gen_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} pc_state_e;
  localparam int INST_BYTES = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0100;
endpackage

// File: rtl/pc_gen_stage_if.sv
// pc_gen_stage_if: control inputs and fetch-address outputs of the PC generation stage.
interface pc_gen_stage_if #(parameter int XLEN = 32);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic [XLEN-1:0] pc_plus4;
  logic            halted;
  logic [XLEN-1:0] fetch_count;
  logic            misalign_trap;
  modport master (
    output stall, redirect_valid, redirect_target, halt_req, resume,
    input  pc, pc_valid, pc_plus4, halted, fetch_count, misalign_trap
  );
  modport slave (
    input  stall, redirect_valid, redirect_target, halt_req, resume,
    output pc, pc_valid, pc_plus4, halted, fetch_count, misalign_trap
  );
endinterface

// File: rtl/pc_gen_stage.sv
// pc_gen_stage: owns the program counter, issues fetch addresses and counts issued fetches.
// Define PC_MISALIGN_TRAP_EN to send misaligned redirects to TRAP_VECTOR with a misalign_trap pulse.
module pc_gen_stage
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR)
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR)
`endif
) (
  input logic           clock,
  input logic           reset,
  pc_gen_stage_if.slave bus
);
  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, cnt_q, cnt_d, tgt;
  logic            take, issue;
  always_ff @(posedge clock)
    if (reset) state_q <= BOOT;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == BOOT ? RUN
            : state_q == RUN ? (bus.halt_req ? HALTED : RUN)
            : (bus.resume && !bus.halt_req ? RUN : HALTED);
  end
  always_comb begin
    bus.pc_valid    = state_q == RUN;
    bus.halted      = state_q == HALTED;
    bus.pc          = pc_q;
    bus.pc_plus4    = pc_q + XLEN'(INST_BYTES);
    bus.fetch_count = cnt_q;
  end
  // A redirect is honoured in RUN and HALTED alike so a late branch is never lost.
  assign take  = bus.redirect_valid && state_q != BOOT;
  assign issue = state_q == RUN && !bus.stall;
`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q, misal;
  assign misal = |bus.redirect_target[1:0];
  assign tgt   = misal ? TRAP_VECTOR : bus.redirect_target;
  always_ff @(posedge clock)
    if (reset) trap_q <= 1'b0;
    else trap_q <= take && misal;
  assign bus.misalign_trap = trap_q;
`else
  assign tgt = bus.redirect_target & ~XLEN'(INST_BYTES - 1);
  assign bus.misalign_trap = 1'b0;
`endif
  always_comb begin
    pc_d  = take ? tgt : issue ? pc_q + XLEN'(INST_BYTES) : pc_q;
    cnt_d = cnt_q + XLEN'(issue);
  end
  always_ff @(posedge clock)
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: doc/pc_gen_stage.md
Name: pc_gen_stage

Overview:
- Stage directly upstream of the fetch stage; owns the program counter and drives the `pc` input of instruction memory and fetch.
- Default step is PC+4 (ILEN 32, no compressed instructions).
- Takes a branch/jump redirect from execute, a stall from the hazard unit, and halt/resume from the debug/control path.
- Counts issued fetches for performance monitoring.

Parameters:
- XLEN, 32, width of pc, redirect target and fetch counter
- RESET_VECTOR, 32'h0000_0000, first PC fetched after reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect (only used with PC_MISALIGN_TRAP_EN)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold pc; fetch/decode cannot accept a new instruction
- redirect_valid  input  1  execute resolved a taken branch/jump this cycle
- redirect_target  input  XLEN  new PC when redirect_valid
- halt_req  input  1  request to stop issuing PCs
- resume  input  1  leave HALTED
- pc  output  XLEN  current fetch address, to inst_mem/fetch_stage
- pc_valid  output  1  pc is a live fetch request this cycle
- pc_plus4  output  XLEN  pc+4, combinational, for link-address use
- halted  output  1  state is HALTED
- fetch_count  output  XLEN  number of issued fetches
- misalign_trap  output  1  one-cycle pulse (PC_MISALIGN_TRAP_EN only; otherwise tied 0)

Behaviour:
- States: BOOT, RUN, HALTED. All flops are synchronous; reset is checked only on the clock edge.
- Reset (and reset asserted mid-operation):
  - state=BOOT, pc=RESET_VECTOR, pc_valid=0, halted=0, fetch_count=0, misalign_trap=0.
  - All other inputs are ignored while reset is high.
- BOOT: the first edge after reset deasserts moves to RUN. pc stays RESET_VECTOR and pc_valid=1 from that cycle on.
- RUN: per edge, evaluate in priority order:
  1. redirect_valid: pc<=redirect_target. This overrides stall, because a stalled wrong-path fetch is discarded.
  2. stall: pc holds.
  3. Otherwise: pc<=pc+4, modulo 2^XLEN; 0xFFFF_FFFC wraps to 0x0.
- halt_req in RUN: next state HALTED; a same-cycle redirect still loads pc.
- pc_valid = (state==RUN). halted = (state==HALTED). pc_valid is a registered decode of the state.
- HALTED:
  - pc holds; redirect_valid still loads pc, so a late-resolving branch is not lost; stall is ignored.
  - resume: next state RUN, no pc change. halt_req and resume together: halt_req wins, stay HALTED.
- fetch_count: increments on edges where pc_valid=1 and stall=0, including redirect cycles. Wraps modulo 2^XLEN.
- Latency: a redirect presented in cycle N shows at pc in cycle N+1. No bubble is inserted; flushing the wrong-path instruction is the pipeline control's job.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - If a redirect is taken with redirect_target[1:0]!=0, pc<=TRAP_VECTOR and misalign_trap pulses 1 in the following cycle.
  - Same state transitions as a normal redirect.
- Undefined:
  - Target bits [1:0] are forced to 0 on load.
  - misalign_trap is constant 0 and no TRAP_VECTOR logic is built.

Decomposition:
- Package pc_gen_pkg holds:
  - state enum pc_state_e {BOOT, RUN, HALTED}, 2-bit
  - localparam INST_BYTES=4
  - default reset/trap vector constants
- No sub-module is needed; next-PC mux and counter fit in one module.

Test Plan:
- Reset, then release with no stall → cycle 1: pc=0x0, pc_valid=1; following cycles 0x4, 0x8, 0xC; fetch_count=3 after 3 issued cycles.
- stall high 2 cycles at pc=0x8 → pc holds 0x8 and fetch_count holds; stall low → pc=0xC.
- stall=1 and redirect_valid=1 with target 0x40 at pc=0x10 → next pc=0x40; then 0x44 once stall drops.
- halt_req at pc=0x20 → halted=1, pc_valid=0, pc=0x24 frozen; redirect to 0x80 while halted → pc=0x80; resume → RUN, pc_valid=1 at 0x80, then 0x84.
- Redirect target 0x102:
  - with PC_MISALIGN_TRAP_EN → pc=0x100 and misalign_trap pulses one cycle;
  - without it → pc=0x100 and misalign_trap stays 0.
- pc at 0xFFFF_FFFC with no stall → wraps to 0x0. reset asserted mid-run at pc=0x30 → pc=RESET_VECTOR, pc_valid=0, fetch_count=0 on that edge.
